// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding, default polynomial constants
// and the next-state function, used by both the pattern generator and the checker.
package lfsr_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_TAP   = 2;
    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // Fibonacci step: shift left, feed back msb ^ tap into bit 0, mask to width.
    function automatic logic [MAX_WIDTH-1:0] lfsr_next(
        input logic [MAX_WIDTH-1:0] cur,
        input int unsigned          width,
        input int unsigned          tap
    );
        logic [MAX_WIDTH-1:0] nxt;
        logic [MAX_WIDTH-1:0] mask;
        nxt  = {cur[MAX_WIDTH-2:0], cur[$clog2(MAX_WIDTH)'(width - 1)] ^ cur[$clog2(MAX_WIDTH)'(tap)]};
        mask = MAX_WIDTH'((64'(1) << width) - 64'(1));
        return nxt & mask;
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Receive-word and status bundle between the link front end and the LFSR checker.
interface lfsr_seq_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             locked;
    logic             err_pulse;
    logic             lost_pulse;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_data,
        input  locked, err_pulse, lost_pulse, err_count
    );

    modport slave (
        input  in_valid, in_data,
        output locked, err_pulse, lost_pulse, err_count
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the Fibonacci LFSR pattern stream.
// Define LFSR_CHK_ERR_COUNT_EN to implement the saturating err_count; otherwise it reads 0.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned TAP        = DEF_TAP,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_seq_checker_if.slave  bus
);

    localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BR_W = $clog2(LOSS_COUNT + 1);

    localparam logic [MC_W-1:0] LAST_MATCH = MC_W'(LOCK_COUNT - 1);
    localparam logic [BR_W-1:0] LAST_BAD   = BR_W'(LOSS_COUNT - 1);

    function automatic logic [WIDTH-1:0] next_of(input logic [WIDTH-1:0] cur);
        return WIDTH'(lfsr_next(MAX_WIDTH'(cur), WIDTH, TAP));
    endfunction

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] pred_q, pred_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [BR_W-1:0]  bad_q, bad_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;

    logic zero_word;
    logic hit;

    assign zero_word = (bus.in_data == '0);
    assign hit       = (bus.in_data == pred_q);

    // State and datapath registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            pred_q   <= '0;
            match_q  <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            lost_q   <= lost_d;
        end
    end

    // Next-state and predictor update; nothing moves without in_valid.
    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        bad_d   = bad_q;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (!zero_word) begin
                        pred_d  = next_of(bus.in_data);
                        match_d = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (zero_word) begin
                        match_d = '0;
                        state_d = HUNT;
                    end else if (hit) begin
                        pred_d = next_of(bus.in_data);
                        if (match_q == LAST_MATCH) begin
                            match_d = '0;
                            bad_d   = '0;
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + MC_W'(1);
                        end
                    end else begin
                        pred_d  = next_of(bus.in_data);
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the predictor free-runs and is never reseeded here.
                    pred_d = next_of(pred_q);
                    if (hit) begin
                        bad_d = '0;
                    end else if (bad_q == LAST_BAD) begin
                        bad_d   = '0;
                        match_d = '0;
                        state_d = HUNT;
                    end else begin
                        bad_d = bad_q + BR_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Next values of the registered status outputs.
    always_comb begin
        locked_d = (state_d == LOCKED);
        err_d    = 1'b0;
        lost_d   = 1'b0;
        if (bus.in_valid && (state_q == LOCKED) && !hit) begin
            err_d  = 1'b1;
            lost_d = (bad_q == LAST_BAD);
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_q;
    assign bus.lost_pulse = lost_q;

`ifdef LFSR_CHK_ERR_COUNT_EN
    logic [CNT_W-1:0] err_count_q;

    // Saturating mismatch counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (err_d && (err_count_q != '1)) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = '0;
`endif

endmodule
